// File: rtl/fft_pkg.sv
// Shared types for the FFT front end (input loader and fft_control).
package fft_pkg;

  // Default sample width; modules that carry a DATA_W parameter size their own datapath.
  localparam int unsigned SampleW = 16;

  typedef struct packed {
    logic signed [SampleW-1:0] re;
    logic signed [SampleW-1:0] im;
  } sample_t;

  // One-hot write enable, one bit per data RAM bank.
  typedef logic [3:0] bank_we_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    KICK,
    BUSY
  } loader_state_t;

  // Reverse the low 'width' bits of 'value'; bits at or above 'width' come back as zero.
  function automatic logic [31:0] bit_reverse(input logic [31:0] value, input int unsigned width);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < width) begin
        r[5'(width - 1 - i)] = value[5'(i)];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_addr_bitrev.sv
// Maps a natural-order sample index to its bit-reversed {bank, address} location.
module fft_addr_bitrev #(
  parameter int unsigned LOG_N = 8
) (
  input  logic [LOG_N-1:0] k_i,
  output logic [1:0]       bank_o,
  output logic [LOG_N-3:0] addr_o
);

  logic [LOG_N-1:0] rev;

  for (genvar i = 0; i < LOG_N; i++) begin : g_rev
    assign rev[i] = k_i[LOG_N-1-i];
  end

  // Low two reversed bits pick the bank so consecutive butterflies hit different banks.
  assign bank_o = rev[1:0];
  assign addr_o = rev[LOG_N-1:2];

endmodule

// File: rtl/fft_input_loader.sv
// Streams one complex frame into the four data banks in bit-reversed order, then kicks
// fft_control and holds off new input until the transform completes.
module fft_input_loader
  import fft_pkg::*;
#(
  parameter int unsigned N_POINTS = 256,
  parameter int unsigned DATA_W   = 16
) (
  input  logic                     iCLK,
  input  logic                     iRESET,
  input  logic                     iVALID,
  input  logic [DATA_W-1:0]        iDATA_RE,
  input  logic [DATA_W-1:0]        iDATA_IM,
  output logic                     oREADY,
  input  logic                     iFLUSH,
  output logic [3:0]               oWE,
  output logic [$clog2(N_POINTS)-3:0] oADDR_WR,
  output logic [DATA_W-1:0]        oDATA_RE,
  output logic [DATA_W-1:0]        oDATA_IM,
  output logic                     oSTART,
  input  logic                     iFFT_RDY,
  output logic                     oBUSY
);

  localparam int unsigned LOG_N  = $clog2(N_POINTS);
  localparam int unsigned ADDR_W = LOG_N - 2;
  localparam logic [LOG_N-1:0] LastIdx = LOG_N'(N_POINTS - 1);

  loader_state_t     state_q, state_d;
  logic [LOG_N-1:0]  cnt_q, cnt_d;
  // Holds oREADY low through reset and for the first edge after release.
  logic              live_q;

  bank_we_t          we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] re_q, re_d;
  logic [DATA_W-1:0] im_q, im_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;

  logic              xfer;
  logic              accept;
  logic              last;
  logic [1:0]        bank;
  logic [ADDR_W-1:0] bank_addr;

  fft_addr_bitrev #(
    .LOG_N(LOG_N)
  ) u_bitrev (
    .k_i   (cnt_q),
    .bank_o(bank),
    .addr_o(bank_addr)
  );

  assign oREADY = live_q && ((state_q == IDLE) || (state_q == LOAD));
  assign xfer   = iVALID && oREADY;
  // Flush wins over a coincident transfer.
  assign accept = xfer && !iFLUSH;
  assign last   = (cnt_q == LastIdx);

  // Next-state and sample counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          state_d = LOAD;
          cnt_d   = LOG_N'(1);
        end
      end
      LOAD: begin
        if (iFLUSH) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (accept) begin
          if (last) begin
            state_d = KICK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + LOG_N'(1);
          end
        end
      end
      KICK: begin
        state_d = BUSY;
      end
      BUSY: begin
        if (iFFT_RDY) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Next values of the registered bank-write and control outputs.
  always_comb begin
    we_d    = accept ? bank_we_t'(4'b0001 << bank) : '0;
    addr_d  = accept ? bank_addr : addr_q;
    re_d    = accept ? iDATA_RE : re_q;
    im_d    = accept ? iDATA_IM : im_q;
    // Start lines up with the write of the final sample.
    start_d = accept && (state_q == LOAD) && last;
    busy_d  = (state_d == KICK) || (state_d == BUSY);
  end

  // FSM, counter and output registers.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      live_q  <= 1'b0;
      we_q    <= '0;
      addr_q  <= '0;
      re_q    <= '0;
      im_q    <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      live_q  <= 1'b1;
      we_q    <= we_d;
      addr_q  <= addr_d;
      re_q    <= re_d;
      im_q    <= im_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

  assign oWE      = we_q;
  assign oADDR_WR = addr_q;
  assign oDATA_RE = re_q;
  assign oDATA_IM = im_q;
  assign oSTART   = start_q;
  assign oBUSY    = busy_q;

endmodule

// File: tb/tb_fft_input_loader.sv
// Directed bench for fft_input_loader with N_POINTS = 16 and a frame-level reference model.
module tb_fft_input_loader;

  localparam int N  = 16;
  localparam int DW = 16;

  logic          iCLK = 1'b0;
  logic          iRESET = 1'b0;
  logic          iVALID = 1'b0;
  logic          iFLUSH = 1'b0;
  logic          iFFT_RDY = 1'b0;
  logic [DW-1:0] iDATA_RE = '0;
  logic [DW-1:0] iDATA_IM = '0;
  logic          oREADY;
  logic [3:0]    oWE;
  logic [1:0]    oADDR_WR;
  logic [DW-1:0] oDATA_RE;
  logic [DW-1:0] oDATA_IM;
  logic          oSTART;
  logic          oBUSY;

  fft_input_loader #(
    .N_POINTS(N),
    .DATA_W  (DW)
  ) dut (
    .iCLK    (iCLK),
    .iRESET  (iRESET),
    .iVALID  (iVALID),
    .iDATA_RE(iDATA_RE),
    .iDATA_IM(iDATA_IM),
    .oREADY  (oREADY),
    .iFLUSH  (iFLUSH),
    .oWE     (oWE),
    .oADDR_WR(oADDR_WR),
    .oDATA_RE(oDATA_RE),
    .oDATA_IM(oDATA_IM),
    .oSTART  (oSTART),
    .iFFT_RDY(iFFT_RDY),
    .oBUSY   (oBUSY)
  );

  always #5 iCLK = ~iCLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame position, "frame done, waiting for FFT", and expected outputs.
  logic          m_live = 1'b0;
  int            m_k = 0;
  logic          m_wait = 1'b0;
  logic          m_kick = 1'b0;
  logic [3:0]    exp_we = '0;
  logic [1:0]    exp_addr = '0;
  logic [DW-1:0] exp_re = '0;
  logic [DW-1:0] exp_im = '0;
  logic          exp_start = 1'b0;
  logic          exp_busy = 1'b0;
  logic          m_rdy, m_acc, m_nwait;

  function automatic int rev4(input int k);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) r = r * 2 + ((k >> i) & 1);
    return r;
  endfunction

  always @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      m_live <= 1'b0; m_k <= 0; m_wait <= 1'b0; m_kick <= 1'b0;
      exp_we <= '0; exp_addr <= '0; exp_re <= '0; exp_im <= '0;
      exp_start <= 1'b0; exp_busy <= 1'b0;
    end else begin
      m_rdy = m_live && !m_wait;
      m_acc = iVALID && m_rdy && !iFLUSH;
      exp_we <= m_acc ? 4'(4'b0001 << (rev4(m_k) % 4)) : 4'b0000;
      if (m_acc) begin
        exp_addr <= 2'(rev4(m_k) / 4);
        exp_re   <= iDATA_RE;
        exp_im   <= iDATA_IM;
      end
      exp_start <= m_acc && (m_k == N - 1);
      m_kick    <= m_acc && (m_k == N - 1);
      if (m_rdy && iFLUSH) m_k <= 0;
      else if (m_acc) m_k <= (m_k == N - 1) ? 0 : m_k + 1;
      m_nwait = m_wait;
      if (m_acc && (m_k == N - 1)) m_nwait = 1'b1;
      else if (m_wait && !m_kick && iFFT_RDY) m_nwait = 1'b0;
      m_wait   <= m_nwait;
      exp_busy <= m_nwait;
      m_live   <= 1'b1;
    end
  end

  // Tallies and per-sample captures, keyed by the low bits of the real part.
  int         wr_cnt = 0;
  int         st_cnt = 0;
  logic [15:0] seen = '0;
  logic [3:0] cap_we [16];
  logic [1:0] cap_addr [16];
  logic [3:0] st_we = '0;

  always @(negedge iCLK) begin
    int bk;
    check("ready", 32'(oREADY), 32'(m_live && !m_wait));
    check("we", 32'(oWE), 32'(exp_we));
    check("addr", 32'(oADDR_WR), 32'(exp_addr));
    check("data_re", 32'(oDATA_RE), 32'(exp_re));
    check("data_im", 32'(oDATA_IM), 32'(exp_im));
    check("start", 32'(oSTART), 32'(exp_start));
    check("busy", 32'(oBUSY), 32'(exp_busy));
    if (oWE != 4'b0000) begin
      wr_cnt++;
      bk = 0;
      for (int b = 0; b < 4; b++) if (oWE[b]) bk = b;
      seen[oADDR_WR * 4 + bk] = 1'b1;
      cap_we[oDATA_RE[3:0]]   = oWE;
      cap_addr[oDATA_RE[3:0]] = oADDR_WR;
    end
    if (oSTART) begin
      st_cnt++;
      st_we = oWE;
    end
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic clear_tally();
    wr_cnt = 0;
    st_cnt = 0;
    seen = '0;
    for (int i = 0; i < 16; i++) begin
      cap_we[i] = '0;
      cap_addr[i] = '0;
    end
  endtask

  // Offer samples k = 0..n-1 (re = k, im = -k) until n transfers have happened.
  task automatic send_frame(input int n, input bit gappy);
    int   idx;
    int   budget;
    logic will;
    idx = 0;
    budget = 0;
    while (idx < n && budget < 1000) begin
      iVALID   = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
      iDATA_RE = DW'(idx);
      iDATA_IM = DW'(-idx);
      will     = iVALID && m_live && !m_wait && !iFLUSH;
      tick();
      if (will) idx++;
      budget++;
    end
    iVALID = 1'b0;
    check("send_budget", 32'(idx), 32'(n));
  endtask

  task automatic fft_done();
    iFFT_RDY = 1'b1;
    tick();
    iFFT_RDY = 1'b0;
    check("rdy_after_fft", 32'(oREADY), 32'd1);
    check("busy_after_fft", 32'(oBUSY), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int snap;
    // 1. Reset then idle
    iRESET = 1'b0;
    repeat (2) @(posedge iCLK);
    #1 iRESET = 1'b1;
    clear_tally();
    repeat (100) tick();
    check("s1_no_start", 32'(st_cnt), 32'd0);
    check("s1_ready", 32'(oREADY), 32'd1);

    // 2/3. Address mapping, start pulse, blocking while busy
    clear_tally();
    send_frame(16, 1'b0);
    iVALID = 1'b1;
    tick();
    check("s2_writes", 32'(wr_cnt), 32'd16);
    check("s2_distinct", 32'(seen), 32'hFFFF);
    check("s2_k1_we", 32'(cap_we[1]), 32'b0001);
    check("s2_k1_addr", 32'(cap_addr[1]), 32'd2);
    check("s2_k5_we", 32'(cap_we[5]), 32'b0100);
    check("s2_k5_addr", 32'(cap_addr[5]), 32'd2);
    check("s2_k3_we", 32'(cap_we[3]), 32'b0001);
    check("s2_k3_addr", 32'(cap_addr[3]), 32'd3);
    check("s2_k15_we", 32'(cap_we[15]), 32'b1000);
    check("s2_k15_addr", 32'(cap_addr[15]), 32'd3);
    check("s3_one_start", 32'(st_cnt), 32'd1);
    check("s3_start_with_last_we", 32'(st_we), 32'b1000);
    repeat (50) tick();
    check("s3_no_busy_writes", 32'(wr_cnt), 32'd16);
    check("s3_single_start", 32'(st_cnt), 32'd1);
    check("s3_ready_low", 32'(oREADY), 32'd0);
    check("s3_busy_high", 32'(oBUSY), 32'd1);
    iVALID = 1'b0;
    fft_done();

    // 4. Gapped input
    clear_tally();
    send_frame(16, 1'b1);
    repeat (2) tick();
    check("s4_writes", 32'(wr_cnt), 32'd16);
    check("s4_distinct", 32'(seen), 32'hFFFF);
    check("s4_k5_we", 32'(cap_we[5]), 32'b0100);
    check("s4_k15_addr", 32'(cap_addr[15]), 32'd3);
    check("s4_one_start", 32'(st_cnt), 32'd1);
    fft_done();

    // 5. Flush with a coincident transfer
    clear_tally();
    send_frame(7, 1'b0);
    iVALID = 1'b1;
    iFLUSH = 1'b1;
    iDATA_RE = DW'(7);
    tick();
    iVALID = 1'b0;
    iFLUSH = 1'b0;
    tick();
    check("s5_flush_no_write", 32'(wr_cnt), 32'd7);
    check("s5_ready_after_flush", 32'(oREADY), 32'd1);
    clear_tally();
    send_frame(16, 1'b0);
    tick();
    check("s5_k0_we", 32'(cap_we[0]), 32'b0001);
    check("s5_k0_addr", 32'(cap_addr[0]), 32'd0);
    check("s5_writes", 32'(wr_cnt), 32'd16);
    check("s5_one_start", 32'(st_cnt), 32'd1);
    fft_done();

    // 6. Reset mid-frame, spurious FFT ready in LOAD, reset during BUSY
    clear_tally();
    send_frame(9, 1'b0);
    iRESET = 1'b0;
    repeat (2) tick();
    iRESET = 1'b1;
    tick();
    check("s6_no_start_after_reset", 32'(st_cnt), 32'd0);
    check("s6_ready_after_reset", 32'(oREADY), 32'd1);
    send_frame(5, 1'b0);
    iFFT_RDY = 1'b1;
    tick();
    iFFT_RDY = 1'b0;
    check("s6_spurious_rdy_ready", 32'(oREADY), 32'd1);
    send_frame(11, 1'b0);
    snap = st_cnt;
    repeat (3) tick();
    check("s6_frame_start", 32'(st_cnt), 32'(snap + 1));
    check("s6_busy", 32'(oBUSY), 32'd1);
    iRESET = 1'b0;
    repeat (2) tick();
    iRESET = 1'b1;
    tick();
    check("s6_busy_cleared", 32'(oBUSY), 32'd0);
    check("s6_ready_restored", 32'(oREADY), 32'd1);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
